// File: rtl/dm9000a_bus_access.sv
// DM9000A register access sequencer: index write then data read/write,
// optional post-access delay. Macro DM9000A_DLY_TIMEOUT_EN adds a wait timeout.
module dm9000a_bus_access #(
  parameter int PULSE_CYC   = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic        iDm9000aClk,
  input  logic        iRst,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrite,
  input  logic [7:0]  iReqAddr,
  input  logic [15:0] iReqWdata,
  input  logic [10:0] iReqWait,
  output logic        oRspValid,
  output logic [15:0] oRspRdata,
  output logic        oRspErr,
  output logic        oDmCs_n,
  output logic        oDmCmd,
  output logic        oDmIor_n,
  output logic        oDmIow_n,
  output logic [15:0] oDmDataOut,
  output logic        oDmDataOe,
  input  logic [15:0] iDmDataIn,
  output logic        oDelayRun,
  output logic [10:0] oDelayTime,
  input  logic        iDelayEnd
);

  typedef enum logic [3:0] {
    S_IDLE, S_IDX_SETUP, S_IDX_PULSE, S_IDX_REC,
    S_DAT_SETUP, S_DAT_PULSE, S_DAT_REC, S_WAIT_DLY, S_DONE
  } state_e;

  localparam logic [7:0] P_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0] R_LAST = 8'(RECOVER_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [10:0] wait_q, wait_d;
  logic [15:0] cap_q, cap_d;
  logic        err_d;

  logic        ready_q, ready_d;
  logic        rspv_q, rspv_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rerr_q;
  logic        cs_n_q, cs_n_d;
  logic        cmd_q, cmd_d;
  logic        ior_n_q, ior_n_d;
  logic        iow_n_q, iow_n_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        run_q, run_d;
  logic [10:0] time_q, time_d;

`ifdef DM9000A_DLY_TIMEOUT_EN
  logic [11:0] tcnt_q, tcnt_d;
  logic        tmo;
  assign tmo = (tcnt_q == ({1'b0, wait_q} + 12'd3));
  assign tcnt_d = (state_q == S_WAIT_DLY) ? tcnt_q + 12'd1 : 12'd0;
  // Wait-phase timeout counter, cleared outside WAIT_DLY
  always_ff @(posedge iDm9000aClk) begin
    if (iRst) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end
`else
  logic tmo;
  assign tmo = 1'b0;
`endif

  // Next-state, request latching and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    cap_d   = cap_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (iReqValid) begin
        write_d = iReqWrite;
        addr_d  = iReqAddr;
        wdata_d = iReqWdata;
        wait_d  = iReqWait;
        cap_d   = '0;
        cnt_d   = '0;
        state_d = S_IDX_SETUP;
      end
      S_IDX_SETUP: begin
        cnt_d   = '0;
        state_d = S_IDX_PULSE;
      end
      S_IDX_PULSE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == P_LAST) begin
          cnt_d   = '0;
          state_d = S_IDX_REC;
        end
      end
      S_IDX_REC: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          state_d = S_DAT_SETUP;
        end
      end
      S_DAT_SETUP: begin
        cnt_d   = '0;
        state_d = S_DAT_PULSE;
      end
      S_DAT_PULSE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == P_LAST) begin
          if (!write_q) cap_d = iDmDataIn;
          cnt_d   = '0;
          state_d = S_DAT_REC;
        end
      end
      S_DAT_REC: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == R_LAST) begin
          cnt_d   = '0;
          state_d = (wait_q != '0) ? S_WAIT_DLY : S_DONE;
        end
      end
      S_WAIT_DLY: begin
        if (iDelayEnd) begin
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every pin is a flop
  always_comb begin
    ready_d = 1'b0;
    rspv_d  = 1'b0;
    rdata_d = '0;
    cs_n_d  = 1'b1;
    cmd_d   = 1'b0;
    ior_n_d = 1'b1;
    iow_n_d = 1'b1;
    dout_d  = '0;
    oe_d    = 1'b0;
    run_d   = 1'b0;
    time_d  = '0;
    unique case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_IDX_SETUP, S_IDX_PULSE, S_IDX_REC: begin
        cs_n_d  = 1'b0;
        dout_d  = {8'h00, addr_d};
        oe_d    = 1'b1;
        iow_n_d = (state_d != S_IDX_PULSE);
      end
      S_DAT_SETUP, S_DAT_PULSE, S_DAT_REC: begin
        cs_n_d = 1'b0;
        cmd_d  = 1'b1;
        dout_d = write_d ? wdata_d : 16'h0000;
        oe_d   = write_d;
        if (state_d == S_DAT_PULSE) begin
          iow_n_d = !write_d;
          ior_n_d = write_d;
        end
      end
      S_WAIT_DLY: begin
        run_d  = 1'b1;
        time_d = wait_d;
      end
      S_DONE: begin
        rspv_d  = 1'b1;
        rdata_d = write_d ? 16'h0000 : cap_d;
      end
      default: ready_d = 1'b0;
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge iDm9000aClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      cap_q   <= '0;
      ready_q <= 1'b1;
      rspv_q  <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      cmd_q   <= 1'b0;
      ior_n_q <= 1'b1;
      iow_n_q <= 1'b1;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      run_q   <= 1'b0;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      cap_q   <= cap_d;
      ready_q <= ready_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
      rerr_q  <= err_d;
      cs_n_q  <= cs_n_d;
      cmd_q   <= cmd_d;
      ior_n_q <= ior_n_d;
      iow_n_q <= iow_n_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      run_q   <= run_d;
      time_q  <= time_d;
    end
  end

  assign oReqReady  = ready_q;
  assign oRspValid  = rspv_q;
  assign oRspRdata  = rdata_q;
  assign oRspErr    = rerr_q;
  assign oDmCs_n    = cs_n_q;
  assign oDmCmd     = cmd_q;
  assign oDmIor_n   = ior_n_q;
  assign oDmIow_n   = iow_n_q;
  assign oDmDataOut = dout_q;
  assign oDmDataOe  = oe_q;
  assign oDelayRun  = run_q;
  assign oDelayTime = time_q;

endmodule
